// File: rtl/aes_inv_key_expand_128.sv
// ---------------------------------------------------------------------------
// aes_inv_key_expand_128
//   Inverse AES-128 key schedule for the decryption datapath. A round-10 key
//   is loaded and each advance request walks the schedule back by one round,
//   presenting round keys 10, 9, ... 0 on wo_0..wo_3.
//
//   Optional feature (macro AES_INV_KEY_EXPAND_PRELOAD_EN):
//   key is the cipher key instead. After a load the block runs the forward
//   schedule for 10 cycles (busy=1, state EXPAND). It reuses the same four
//   S-boxes to reach round 10, and then walks back as usual.
//
//   Ports:
//     clk          clock, rising edge
//     rst          asynchronous active-low reset
//     kld          key load strobe (has priority over adv)
//     key[127:0]   key to load, key[127:96] = w0 ... key[31:0] = w3
//     adv          step to the previous round
//     wo_0..wo_3   current round key words (registered)
//     rnd[3:0]     round index of the key on wo_*
//     busy         forward expansion in progress (0 without the feature)
//     done         READY with rnd == 0
//
//   Also contains aes_sbox, the forward AES S-box lookup.
// ---------------------------------------------------------------------------

// Forward AES S-box; byte 0x00 sits in the most significant byte of the table.
module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] d_o
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] idx;

    assign idx = {8'hff - a_i, 3'b000};
    assign d_o = SBOX[idx +: 8];
endmodule

module aes_inv_key_expand_128 (
    input  logic         clk,
    input  logic         rst,
    input  logic         kld,
    input  logic [127:0] key,
    input  logic         adv,
    output logic [31:0]  wo_0,
    output logic [31:0]  wo_1,
    output logic [31:0]  wo_2,
    output logic [31:0]  wo_3,
    output logic [3:0]   rnd,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READY  = 2'd1,
        EXPAND = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] w0_q, w1_q, w2_q, w3_q;
    logic [31:0] w0_d, w1_d, w2_d, w3_d;
    logic [3:0]  rnd_q, rnd_d;

    logic [31:0] n0, n1, n2, n3;
    logic [31:0] sb_in, sb_rot, sb_out;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    // Stepping back one round: the last three words fall out of the XOR chain,
    // and only the first word needs the S-box, fed from the recovered w3.
    assign n3 = w3_q ^ w2_q;
    assign n2 = w2_q ^ w1_q;
    assign n1 = w1_q ^ w0_q;

`ifdef AES_INV_KEY_EXPAND_PRELOAD_EN
    logic [31:0] f0, f1, f2, f3;

    // The forward step shares the S-boxes; during EXPAND they see w3 instead of n3.
    assign sb_in = (state_q == EXPAND) ? w3_q : n3;
    assign f0    = w0_q ^ sb_out ^ {rcon(rnd_q + 4'd1), 24'h0};
    assign f1    = f0 ^ w1_q;
    assign f2    = f1 ^ w2_q;
    assign f3    = f2 ^ w3_q;
    assign busy  = (state_q == EXPAND);
`else
    assign sb_in = n3;
    assign busy  = 1'b0;
`endif

    assign sb_rot = {sb_in[23:0], sb_in[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .a_i (sb_rot[8*i +: 8]),
            .d_o (sb_out[8*i +: 8])
        );
    end

    assign n0 = w0_q ^ sb_out ^ {rcon(rnd_q), 24'h0};

    always_comb begin
        state_d = state_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        w3_d    = w3_q;
        rnd_d   = rnd_q;
        if (kld) begin
            w0_d = key[127:96];
            w1_d = key[95:64];
            w2_d = key[63:32];
            w3_d = key[31:0];
`ifdef AES_INV_KEY_EXPAND_PRELOAD_EN
            rnd_d   = 4'd0;
            state_d = EXPAND;
`else
            rnd_d   = 4'd10;
            state_d = READY;
`endif
        end else begin
            case (state_q)
                READY: begin
                    if (adv && (rnd_q != 4'd0)) begin
                        w0_d  = n0;
                        w1_d  = n1;
                        w2_d  = n2;
                        w3_d  = n3;
                        rnd_d = rnd_q - 4'd1;
                    end
                end
`ifdef AES_INV_KEY_EXPAND_PRELOAD_EN
                EXPAND: begin
                    w0_d  = f0;
                    w1_d  = f1;
                    w2_d  = f2;
                    w3_d  = f3;
                    rnd_d = rnd_q + 4'd1;
                    // The step taken at rnd 9 produces the round-10 key.
                    if (rnd_q == 4'd9) begin
                        state_d = READY;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            w0_q    <= 32'h0;
            w1_q    <= 32'h0;
            w2_q    <= 32'h0;
            w3_q    <= 32'h0;
            rnd_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            w3_q    <= w3_d;
            rnd_q   <= rnd_d;
        end
    end

    assign wo_0 = w0_q;
    assign wo_1 = w1_q;
    assign wo_2 = w2_q;
    assign wo_3 = w3_q;
    assign rnd  = rnd_q;
    assign done = (state_q == READY) && (rnd_q == 4'd0);
endmodule
